// File: rtl/jtkicker_objrom_slot_pkg.sv
// Shared definitions for the object ROM slot: fetch FSM encoding and the
// default SDRAM base of the object region.
package jtkicker_objrom_slot_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_LO   = 2'd2,
        ST_HI   = 2'd3
    } objrom_state_t;

    localparam logic [21:0] OBJ_OFFSET = 22'h0;

endpackage

// File: rtl/jtkicker_objrom_slot_if.sv
// Object-engine ROM fetch port plus the SDRAM arbiter burst port.
// The slave side is the ROM slot; the master side drives requests and SDRAM replies.
interface jtkicker_objrom_slot_if #(
    parameter int AW = 13
);
    logic          rom_cs;
    logic [AW-1:0] rom_addr;
    logic          rom_ok;
    logic [31:0]   rom_data;
    logic          sdram_req;
    logic [21:0]   sdram_addr;
    logic          sdram_ack;
    logic          sdram_dok;
    logic [15:0]   sdram_data;

    modport slave (
        input  rom_cs, rom_addr, sdram_ack, sdram_dok, sdram_data,
        output rom_ok, rom_data, sdram_req, sdram_addr
    );

    modport master (
        output rom_cs, rom_addr, sdram_ack, sdram_dok, sdram_data,
        input  rom_ok, rom_data, sdram_req, sdram_addr
    );
endinterface

// File: rtl/jtkicker_objrom_slot.sv
// Serves 32-bit object pixel words from a 16-bit SDRAM port with two-word bursts,
// keeping the last fetched word in a one-entry cache.
module jtkicker_objrom_slot
    import jtkicker_objrom_slot_pkg::*;
#(
    parameter int          AW     = 13,
    parameter logic [21:0] OFFSET = OBJ_OFFSET
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    downloading,
    jtkicker_objrom_slot_if.slave   bus
);

    objrom_state_t state_r;
    logic          valid_r;
    logic [AW-1:0] tag_r;
    logic [AW-1:0] req_addr_r;
    logic [31:0]   rom_data_r;
    logic          sdram_req_r;
    logic [21:0]   sdram_addr_r;
    logic          hit_s;
    logic [21:0]   fetch_addr_s;

    // Cache hit and the even-aligned 16-bit SDRAM address of the requested word
    always_comb begin
        hit_s        = valid_r & (tag_r == bus.rom_addr);
        fetch_addr_s = OFFSET + {{(21-AW){1'b0}}, bus.rom_addr, 1'b0};
    end

    assign bus.rom_ok     = bus.rom_cs & hit_s & (state_r == ST_IDLE);
    assign bus.rom_data   = rom_data_r;
    assign bus.sdram_req  = sdram_req_r;
    assign bus.sdram_addr = sdram_addr_r;

    // Fetch FSM and cache registers; a started burst always runs to completion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            valid_r      <= 1'b0;
            tag_r        <= '0;
            req_addr_r   <= '0;
            rom_data_r   <= 32'h0;
            sdram_req_r  <= 1'b0;
            sdram_addr_r <= 22'h0;
        end else begin
            // A download rewrites the ROM, so the cached word is stale every cycle it lasts
            if (downloading) begin
                valid_r <= 1'b0;
            end else begin
                valid_r <= valid_r;
            end
            case (state_r)
                ST_IDLE: begin
                    if (bus.rom_cs && !hit_s && !downloading) begin
                        req_addr_r   <= bus.rom_addr;
                        sdram_addr_r <= fetch_addr_s;
                        sdram_req_r  <= 1'b1;
                        valid_r      <= 1'b0;
                        state_r      <= ST_REQ;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (bus.sdram_ack) begin
                        sdram_req_r <= 1'b0;
                        // The arbiter may deliver the first word in the accept cycle
                        if (bus.sdram_dok) begin
                            rom_data_r[15:0] <= bus.sdram_data;
                            state_r          <= ST_HI;
                        end else begin
                            state_r <= ST_LO;
                        end
                    end else begin
                        state_r <= ST_REQ;
                    end
                end
                ST_LO: begin
                    if (bus.sdram_dok) begin
                        rom_data_r[15:0] <= bus.sdram_data;
                        state_r          <= ST_HI;
                    end else begin
                        state_r <= ST_LO;
                    end
                end
                ST_HI: begin
                    if (bus.sdram_dok) begin
                        rom_data_r[31:16] <= bus.sdram_data;
                        tag_r             <= req_addr_r;
                        valid_r           <= !downloading;
                        state_r           <= ST_IDLE;
                    end else begin
                        state_r <= ST_HI;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    sdram_req_r <= 1'b0;
                    valid_r     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jtkicker_objrom_slot.sv
// Directed bench for jtkicker_objrom_slot: a per-cycle vector table for the
// basic fetch/hit flow plus hand-written sequences for the multi-cycle corners.
module tb_jtkicker_objrom_slot;

    logic clk;
    logic rst_n;
    logic downloading;
    int   total;
    int   bad;

    jtkicker_objrom_slot_if #(.AW(13)) bus ();

    jtkicker_objrom_slot #(.AW(13), .OFFSET(22'h0)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .downloading (downloading),
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        cs;
        logic [12:0] addr;
        logic        ack;
        logic        dok;
        logic [15:0] d;
        logic        ok;
        logic        req;
        logic [21:0] sa;
        logic [31:0] rd;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Drive one cycle of inputs on the falling edge, then let combinational outputs settle
    task automatic drive(input logic cs, input logic [12:0] addr, input logic ack,
                         input logic dok, input logic [15:0] d, input logic dl);
        @(negedge clk);
        bus.rom_cs     = cs;
        bus.rom_addr   = addr;
        bus.sdram_ack  = ack;
        bus.sdram_dok  = dok;
        bus.sdram_data = d;
        downloading    = dl;
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        downloading    = 1'b0;
        bus.rom_cs     = 1'b0;
        bus.rom_addr   = 13'h0;
        bus.sdram_ack  = 1'b0;
        bus.sdram_dok  = 1'b0;
        bus.sdram_data = 16'h0;

        //           cs    addr      ack   dok   data      ok    req   sdram_addr  rom_data
        vecs[0]  = '{1'b1, 13'h123, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 22'h000000, 32'h00000000};
        vecs[1]  = '{1'b1, 13'h123, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 22'h000246, 32'h00000000};
        vecs[2]  = '{1'b1, 13'h123, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 22'h000246, 32'h00000000};
        vecs[3]  = '{1'b1, 13'h123, 1'b0, 1'b1, 16'hBEEF, 1'b0, 1'b0, 22'h000246, 32'h00000000};
        vecs[4]  = '{1'b1, 13'h123, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 22'h000246, 32'h0000BEEF};
        vecs[5]  = '{1'b1, 13'h123, 1'b0, 1'b1, 16'h1234, 1'b0, 1'b0, 22'h000246, 32'h0000BEEF};
        vecs[6]  = '{1'b1, 13'h123, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 22'h000246, 32'h1234BEEF};
        vecs[7]  = '{1'b0, 13'h123, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 22'h000246, 32'h1234BEEF};
        vecs[8]  = '{1'b1, 13'h123, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 22'h000246, 32'h1234BEEF};
        vecs[9]  = '{1'b1, 13'h123, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b0, 22'h000246, 32'h1234BEEF};
        vecs[10] = '{1'b1, 13'h124, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 22'h000246, 32'h1234BEEF};
        vecs[11] = '{1'b1, 13'h124, 1'b0, 1'b1, 16'hAAAA, 1'b0, 1'b1, 22'h000248, 32'h1234BEEF};
        vecs[12] = '{1'b1, 13'h124, 1'b1, 1'b1, 16'h5678, 1'b0, 1'b1, 22'h000248, 32'h1234BEEF};
        vecs[13] = '{1'b1, 13'h124, 1'b0, 1'b1, 16'h9ABC, 1'b0, 1'b0, 22'h000248, 32'h12345678};
        vecs[14] = '{1'b1, 13'h124, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 22'h000248, 32'h9ABC5678};

        // Reset state
        @(negedge clk);
        #1;
        chk("reset_ok",   {31'h0, bus.rom_ok},    32'h0);
        chk("reset_req",  {31'h0, bus.sdram_req}, 32'h0);
        chk("reset_sa",   {10'h0, bus.sdram_addr}, 32'h0);
        chk("reset_data", bus.rom_data,           32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Cold miss, hit, spurious doks, coincident ack/dok
        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].cs, vecs[i].addr, vecs[i].ack, vecs[i].dok, vecs[i].d, 1'b0);
            chk($sformatf("vec%0d_ok", i),   {31'h0, bus.rom_ok},     {31'h0, vecs[i].ok});
            chk($sformatf("vec%0d_req", i),  {31'h0, bus.sdram_req},  {31'h0, vecs[i].req});
            chk($sformatf("vec%0d_sa", i),   {10'h0, bus.sdram_addr}, {10'h0, vecs[i].sa});
            chk($sformatf("vec%0d_data", i), bus.rom_data,            vecs[i].rd);
        end

        // Address change mid-fetch: first burst fills 0x123, then 0x124 is refetched
        drive(1'b1, 13'h123, 1'b0, 1'b0, 16'h0000, 1'b0);
        chk("chg_miss_ok", {31'h0, bus.rom_ok}, 32'h0);
        drive(1'b1, 13'h123, 1'b1, 1'b0, 16'h0000, 1'b0);
        chk("chg_req1_sa", {10'h0, bus.sdram_addr}, 32'h246);
        drive(1'b1, 13'h124, 1'b0, 1'b1, 16'hBEEF, 1'b0);
        drive(1'b1, 13'h124, 1'b0, 1'b1, 16'h1234, 1'b0);
        chk("chg_hi_data", bus.rom_data, 32'h9ABCBEEF);
        drive(1'b1, 13'h123, 1'b0, 1'b0, 16'h0000, 1'b0);
        chk("chg_tag123_ok",   {31'h0, bus.rom_ok}, 32'h1);
        chk("chg_tag123_data", bus.rom_data, 32'h1234BEEF);
        drive(1'b1, 13'h124, 1'b0, 1'b0, 16'h0000, 1'b0);
        chk("chg_124_miss", {31'h0, bus.rom_ok}, 32'h0);
        drive(1'b1, 13'h124, 1'b1, 1'b0, 16'h0000, 1'b0);
        chk("chg_req2",    {31'h0, bus.sdram_req},  32'h1);
        chk("chg_req2_sa", {10'h0, bus.sdram_addr}, 32'h248);
        drive(1'b1, 13'h124, 1'b0, 1'b1, 16'h0001, 1'b0);
        chk("chg_lo_ok", {31'h0, bus.rom_ok}, 32'h0);
        drive(1'b1, 13'h124, 1'b0, 1'b1, 16'h0002, 1'b0);
        chk("chg_hi_ok", {31'h0, bus.rom_ok}, 32'h0);
        drive(1'b1, 13'h124, 1'b0, 1'b0, 16'h0000, 1'b0);
        chk("chg_done_ok",   {31'h0, bus.rom_ok}, 32'h1);
        chk("chg_done_data", bus.rom_data, 32'h00020001);

        // Download invalidation
        drive(1'b1, 13'h055, 1'b0, 1'b0, 16'h0000, 1'b0);
        drive(1'b1, 13'h055, 1'b1, 1'b0, 16'h0000, 1'b0);
        chk("dl_fill_sa", {10'h0, bus.sdram_addr}, 32'h0AA);
        drive(1'b1, 13'h055, 1'b0, 1'b1, 16'h1111, 1'b0);
        drive(1'b1, 13'h055, 1'b0, 1'b1, 16'h2222, 1'b0);
        drive(1'b1, 13'h055, 1'b0, 1'b0, 16'h0000, 1'b0);
        chk("dl_fill_ok",   {31'h0, bus.rom_ok}, 32'h1);
        chk("dl_fill_data", bus.rom_data, 32'h22221111);
        drive(1'b0, 13'h055, 1'b0, 1'b0, 16'h0000, 1'b1);
        drive(1'b1, 13'h055, 1'b0, 1'b0, 16'h0000, 1'b0);
        chk("dl_inval_ok", {31'h0, bus.rom_ok}, 32'h0);
        drive(1'b1, 13'h055, 1'b1, 1'b0, 16'h0000, 1'b0);
        chk("dl_refetch_req", {31'h0, bus.sdram_req},  32'h1);
        chk("dl_refetch_sa",  {10'h0, bus.sdram_addr}, 32'h0AA);
        drive(1'b1, 13'h055, 1'b0, 1'b1, 16'h3333, 1'b0);
        drive(1'b1, 13'h055, 1'b0, 1'b1, 16'h4444, 1'b1);
        drive(1'b1, 13'h055, 1'b0, 1'b0, 16'h0000, 1'b1);
        chk("dl_inflight_ok", {31'h0, bus.rom_ok}, 32'h0);
        drive(1'b1, 13'h055, 1'b0, 1'b0, 16'h0000, 1'b0);
        chk("dl_blocked_req", {31'h0, bus.sdram_req}, 32'h0);
        chk("dl_inflight_data", bus.rom_data, 32'h44443333);
        drive(1'b1, 13'h055, 1'b1, 1'b0, 16'h0000, 1'b0);
        chk("dl_after_req", {31'h0, bus.sdram_req}, 32'h1);
        drive(1'b1, 13'h055, 1'b0, 1'b1, 16'h5555, 1'b0);
        drive(1'b1, 13'h055, 1'b0, 1'b1, 16'h6666, 1'b0);
        drive(1'b1, 13'h055, 1'b0, 1'b0, 16'h0000, 1'b0);
        chk("dl_final_ok",   {31'h0, bus.rom_ok}, 32'h1);
        chk("dl_final_data", bus.rom_data, 32'h66665555);

        // Reset asserted while the FSM waits for the low word
        drive(1'b1, 13'h010, 1'b0, 1'b0, 16'h0000, 1'b0);
        drive(1'b1, 13'h010, 1'b1, 1'b0, 16'h0000, 1'b0);
        chk("rst_pre_sa", {10'h0, bus.sdram_addr}, 32'h020);
        drive(1'b1, 13'h010, 1'b0, 1'b0, 16'h0000, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_req",  {31'h0, bus.sdram_req},  32'h0);
        chk("rst_mid_ok",   {31'h0, bus.rom_ok},     32'h0);
        chk("rst_mid_data", bus.rom_data,            32'h0);
        chk("rst_mid_sa",   {10'h0, bus.sdram_addr}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 13'h010, 1'b0, 1'b0, 16'h0000, 1'b0);
        chk("rst_post_ok", {31'h0, bus.rom_ok}, 32'h0);
        drive(1'b1, 13'h010, 1'b0, 1'b0, 16'h0000, 1'b0);
        chk("rst_post_req", {31'h0, bus.sdram_req},  32'h1);
        chk("rst_post_sa",  {10'h0, bus.sdram_addr}, 32'h020);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/jtkicker_objrom_slot.md
Name: jtkicker_objrom_slot

Overview:
- Responder for the object engine's ROM fetch port (rom_addr/rom_cs in, rom_data/rom_ok out).
- Serves 32-bit object pixel words from the 16-bit SDRAM arbiter port by issuing two-word bursts.
- Holds a one-entry cache so a repeated address is answered without a new SDRAM access.
- Sits between the object engine and the SDRAM controller, in the clk (48 MHz) domain.

Parameters:
- AW, 13, width of rom_addr; each address selects one 32-bit word.
- OFFSET, 22'h0, 16-bit-word base of the object region in SDRAM, added to every request.

Ports:
- clk  in  1  system clock, 48 MHz
- rst_n  in  1  asynchronous, active-low reset
- downloading  in  1  ROM download in progress; invalidates the cache
- rom_cs  in  1  object engine request
- rom_addr  in  AW  32-bit word address
- rom_ok  out  1  rom_data is valid for the current rom_addr
- rom_data  out  32  {word at odd address, word at even address}
- sdram_req  out  1  burst request to the arbiter
- sdram_addr  out  22  16-bit word address, even-aligned: OFFSET + {rom_addr,1'b0}
- sdram_ack  in  1  one-cycle pulse: request accepted
- sdram_dok  in  1  one-cycle pulse per returned 16-bit word; two per burst
- sdram_data  in  16  returned word

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, valid=0, tag=0, rom_data=0.
  - sdram_req=0, sdram_addr=0.
  - rom_ok=0 follows from the above.
- Hit: hit = valid & (tag==rom_addr). rom_ok = rom_cs & hit & (state==IDLE), combinational. rom_ok is never high while rom_cs=0.
- IDLE:
  - If rom_cs & !hit & !downloading: latch req_addr=rom_addr and drive sdram_addr=OFFSET+{rom_addr,1'b0}.
  - On the same edge, set sdram_req=1 and valid=0; next state REQ.
  - Miss-to-request latency: one clk.
- REQ:
  - Hold sdram_req=1 and sdram_addr stable until sdram_ack.
  - On ack: sdram_req=0; next state LO.
  - If ack and dok arrive in the same cycle, the dok counts as the LO word; next state HI.
- LO: on sdram_dok, store sdram_data into rom_data[15:0]; next state HI.
- HI:
  - On sdram_dok, store sdram_data into rom_data[31:16], set tag=req_addr and valid=1; next state IDLE.
  - rom_ok can rise on the clk after the second dok.
- rom_addr change mid-fetch: the fetch in flight completes for req_addr; the hit compare in IDLE then fails and a new fetch starts. No request is ever aborted.
- rom_cs falling mid-fetch: the fetch completes and the cache fills; no request is issued on the next IDLE cycle.
- downloading=1:
  - Forces valid=0 every cycle and blocks new requests in IDLE.
  - A burst already in flight runs to completion but does not set valid.
- Spurious sdram_dok in IDLE or REQ (before ack): ignored.
- Address arithmetic: 22-bit unsigned add, wraps modulo 2^22. rom_addr is zero-extended.
- rom_data holds its value between fetches. It changes only on dok in LO/HI or on reset.

Decomposition:
- Shared jtkicker package: state encoding (IDLE, REQ, LO, HI as a 2-bit enum) and the default object-region OFFSET constant.
- No sub-module. The block is one FSM plus cache registers; the combinational hit/rom_ok logic stays inline.

Test Plan:
- Reset mid-burst: assert rst_n=0 in state LO -> sdram_req=0, rom_ok=0, rom_data=0 immediately; after release, rom_cs=1 with rom_addr=13'h010 issues a fresh request.
- Cold miss: rom_cs=1, rom_addr=13'h123, OFFSET=0 -> next clk sdram_req=1, sdram_addr=22'h000246. Then ack, then dok data 16'hBEEF, then dok data 16'h1234 -> rom_data=32'h1234BEEF; rom_ok=1 while rom_cs=1 and the address is unchanged.
- Hit: after the fill above, drop rom_cs, then raise rom_cs with 13'h123 again -> rom_ok=1 in the same cycle with no sdram_req.
- Address change mid-fetch: change rom_addr from 13'h123 to 13'h124 while in LO -> the first burst completes with tag=13'h123. Then a second request goes out with sdram_addr=22'h000248, and rom_ok rises only after its two doks.
- Download invalidation: fill 13'h055, pulse downloading=1 for one clk, then rom_cs=1 with 13'h055 -> rom_ok=0 and a new request is issued.
- Ack and dok coincident: sdram_ack and the first sdram_dok arrive in the same cycle -> the state moves straight to HI and the next dok completes the fill with correct word order.
